// File: rtl/ctrl_pipe.sv
// Pipeline control for a five-stage in-order core: E/M/W control ranks,
// load-use stall, branch redirect and ALU operand forwarding selects.
module ctrl_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic       memtoregD,
    input  logic       memwriteD,
    input  logic       alusrcD,
    input  logic       regdstD,
    input  logic       regwriteD,
    input  logic       branchD,
    input  logic [2:0] alucontrolD,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rdD,
    input  logic       zeroE,
    output logic       memtoregE,
    output logic       memwriteE,
    output logic       alusrcE,
    output logic       regwriteE,
    output logic [2:0] alucontrolE,
    output logic [4:0] writeregE,
    output logic [4:0] writeregM,
    output logic [4:0] writeregW,
    output logic       memwriteM,
    output logic       memtoregM,
    output logic       regwriteM,
    output logic       memtoregW,
    output logic       regwriteW,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       pcsrcE
);

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
        logic       branch;
        logic [2:0] alucontrol;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } e_rank_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [4:0] writereg;
    } m_rank_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic [4:0] writereg;
    } w_rank_t;

    e_rank_t    e_reg, e_next;
    m_rank_t    m_reg, m_next;
    w_rank_t    w_reg, w_next;
    logic [4:0] writereg_e;
    logic       pcsrc_e;
    logic       lwstall;

    // Hazard detection works off the instruction currently in execute.
    always_comb begin
        writereg_e = e_reg.regdst ? e_reg.rd : e_reg.rt;
        pcsrc_e    = e_reg.branch & zeroE;
        lwstall    = e_reg.memtoreg & e_reg.regwrite & (writereg_e != 5'd0) &
                     ((writereg_e == rsD) | (writereg_e == rtD));
    end

    // A stalled or squashed decode slot enters execute as an all-zero bubble.
    always_comb begin
        e_next            = '0;
        e_next.memtoreg   = memtoregD;
        e_next.memwrite   = memwriteD;
        e_next.alusrc     = alusrcD;
        e_next.regdst     = regdstD;
        e_next.regwrite   = regwriteD;
        e_next.branch     = branchD;
        e_next.alucontrol = alucontrolD;
        e_next.rs         = rsD;
        e_next.rt         = rtD;
        e_next.rd         = rdD;
        if (lwstall | pcsrc_e) begin
            e_next = '0;
        end
    end

    always_comb begin
        m_next.regwrite = e_reg.regwrite;
        m_next.memtoreg = e_reg.memtoreg;
        m_next.memwrite = e_reg.memwrite;
        m_next.writereg = writereg_e;
        w_next.regwrite = m_reg.regwrite;
        w_next.memtoreg = m_reg.memtoreg;
        w_next.writereg = m_reg.writereg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_reg <= '0;
            m_reg <= '0;
            w_reg <= '0;
        end else begin
            e_reg <= e_next;
            m_reg <= m_next;
            w_reg <= w_next;
        end
    end

    // Operand 0 is rs, operand 1 is rt; the memory stage holds the newer value.
    logic [4:0] src_e [2];
    assign src_e[0] = e_reg.rs;
    assign src_e[1] = e_reg.rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [1:0] sel;
            always_comb begin
                sel = 2'b00;
                if ((src_e[gi] != 5'd0) && m_reg.regwrite && (src_e[gi] == m_reg.writereg)) begin
                    sel = 2'b10;
                end else if ((src_e[gi] != 5'd0) && w_reg.regwrite && (src_e[gi] == w_reg.writereg)) begin
                    sel = 2'b01;
                end
            end
        end
    endgenerate

    assign forwardAE   = g_fwd[0].sel;
    assign forwardBE   = g_fwd[1].sel;

    assign memtoregE   = e_reg.memtoreg;
    assign memwriteE   = e_reg.memwrite;
    assign alusrcE     = e_reg.alusrc;
    assign regwriteE   = e_reg.regwrite;
    assign alucontrolE = e_reg.alucontrol;
    assign writeregE   = writereg_e;
    assign writeregM   = m_reg.writereg;
    assign memwriteM   = m_reg.memwrite;
    assign memtoregM   = m_reg.memtoreg;
    assign regwriteM   = m_reg.regwrite;
    assign writeregW   = w_reg.writereg;
    assign memtoregW   = w_reg.memtoreg;
    assign regwriteW   = w_reg.regwrite;

    // A redirect squashes the stalled instruction anyway, so it wins over the stall.
    assign stallF      = lwstall & ~pcsrc_e;
    assign stallD      = lwstall & ~pcsrc_e;
    assign flushD      = pcsrc_e;
    assign pcsrcE      = pcsrc_e;

endmodule
